spi_slave_param: RTL and testbench

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

---
 rtl/spi_slave_param.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_param.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave with synchronised pins, any CPOL/CPHA,
// configurable width/bit order and single-word RX/TX buffering.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int   CW       = $clog2(DATA_W + 1);
  localparam logic SCK_IDLE = (CPOL != 0);
  localparam logic SMP_RISE = (CPOL == CPHA);
  localparam logic LSB      = (LSB_FIRST != 0);

  logic [SYNC_STAGES-1:0] sck_sq, cs_sq, mosi_sq;
  logic sck_s, cs_s, mosi_s;
  logic sck_prev_q, cs_prev_q;
  logic rise, fall;
  logic smp_q, shf_q, csf_q, csr_q, mbit_q;

  assign sck_s  = sck_sq[SYNC_STAGES-1];
  assign cs_s   = cs_sq[SYNC_STAGES-1];
  assign mosi_s = mosi_sq[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;
  assign fall   = ~sck_s & sck_prev_q;

  // Events are registered once so every consumer sees them aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sq     <= {SYNC_STAGES{SCK_IDLE}};
      cs_sq      <= '1;
      mosi_sq    <= '0;
      sck_prev_q <= SCK_IDLE;
      cs_prev_q  <= 1'b1;
      smp_q      <= 1'b0;
      shf_q      <= 1'b0;
      csf_q      <= 1'b0;
      csr_q      <= 1'b0;
      mbit_q     <= 1'b0;
    end else begin
      sck_sq     <= {sck_sq[SYNC_STAGES-2:0], sck};
      cs_sq      <= {cs_sq[SYNC_STAGES-2:0], cs_n};
      mosi_sq    <= {mosi_sq[SYNC_STAGES-2:0], mosi};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      smp_q      <= ~cs_s & (SMP_RISE ? rise : fall);
      shf_q      <= ~cs_s & (SMP_RISE ? fall : rise);
      csf_q      <= cs_prev_q & ~cs_s;
      csr_q      <= ~cs_prev_q & cs_s;
      mbit_q     <= mosi_s;
    end
  end

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              sel_q, sel_d;
  logic              ovr_q, ovr_d;
  logic              und_q, und_d;
  logic              abt_q, abt_d;
  logic [DATA_W-1:0] rx_next;
  logic              tx_load;

  always_comb begin
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_sh_d     = tx_sh_q;
    sel_d       = sel_q;
    ovr_d       = 1'b0;
    und_d       = 1'b0;
    abt_d       = 1'b0;
    tx_load     = 1'b0;
    rx_next     = LSB ? {mbit_q, rx_sh_q[DATA_W-1:1]}
                      : {rx_sh_q[DATA_W-2:0], mbit_q};

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (csf_q) begin
      sel_d   = 1'b1;
      cnt_d   = '0;
      tx_load = 1'b1;
    end else if (csr_q) begin
      sel_d = 1'b0;
      cnt_d = '0;
      abt_d = (cnt_q != '0);
    end else if (smp_q) begin
      rx_sh_d = rx_next;
      if (cnt_q == CW'(DATA_W - 1)) begin
        cnt_d   = '0;
        tx_load = 1'b1;
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = rx_next;
          rx_valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (shf_q && cnt_q != '0) begin
      tx_sh_d = LSB ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    end

    // An empty holding register at load time sends zeros.
    if (tx_load) begin
      if (hold_full_q) begin
        tx_sh_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sh_d = '0;
        und_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sh_q     <= '0;
      sel_q       <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
      abt_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_sh_q     <= tx_sh_d;
      sel_q       <= sel_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
      abt_q       <= abt_d;
    end
  end

  assign miso        = sel_q & (LSB ? tx_sh_q[0] : tx_sh_q[DATA_W-1]);
  assign miso_oe     = sel_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = ovr_q;
  assign tx_underrun = und_q;
  assign frame_abort = abt_q;
  assign busy        = ~cs_s;

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: four slaves (mode 0 8-bit MSB, modes 1-3 16-bit LSB)
// driven by a behavioural SPI master, with table, directed and random frames.
module tb_spi_slave_param;

  localparam int HALF = 8;
  localparam int LAT  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sck_p[4], csn_p[4], mosi_p[4], txv_p[4], rxr_p[4];
  logic miso_w[4], oe_w[4], txr_w[4], rxv_w[4];
  logic ovr_w[4], und_w[4], abt_w[4], busy_w[4];
  logic [7:0]  txd0, rxd0;
  logic [15:0] txd16[1:3], rxd16[1:3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  spi_slave_param #(.DATA_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .sck(sck_p[0]), .cs_n(csn_p[0]),
    .mosi(mosi_p[0]), .miso(miso_w[0]), .miso_oe(oe_w[0]),
    .tx_data(txd0), .tx_valid(txv_p[0]), .tx_ready(txr_w[0]),
    .rx_data(rxd0), .rx_valid(rxv_w[0]), .rx_ready(rxr_p[0]),
    .rx_overrun(ovr_w[0]), .tx_underrun(und_w[0]),
    .frame_abort(abt_w[0]), .busy(busy_w[0])
  );

  for (genvar g = 1; g < 4; g++) begin : g16
    spi_slave_param #(
      .DATA_W(16), .CPOL(g / 2), .CPHA(g % 2), .LSB_FIRST(1)
    ) u (
      .clk(clk), .rst_n(rst_n), .sck(sck_p[g]), .cs_n(csn_p[g]),
      .mosi(mosi_p[g]), .miso(miso_w[g]), .miso_oe(oe_w[g]),
      .tx_data(txd16[g]), .tx_valid(txv_p[g]), .tx_ready(txr_w[g]),
      .rx_data(rxd16[g]), .rx_valid(rxv_w[g]), .rx_ready(rxr_p[g]),
      .rx_overrun(ovr_w[g]), .tx_underrun(und_w[g]),
      .frame_abort(abt_w[g]), .busy(busy_w[g])
    );
  end

  function automatic logic [31:0] rxval(input int k);
    case (k)
      0:       return {24'b0, rxd0};
      1:       return {16'b0, rxd16[1]};
      2:       return {16'b0, rxd16[2]};
      default: return {16'b0, rxd16[3]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observers: pulse counters, delivered words, rx_valid rise time.
  logic [31:0] got[4][$];
  logic [31:0] txq[4][$];
  int ovr_n[4], und_n[4], abt_n[4], rv_cyc[4], smp_cyc[4];
  logic rxv_prev[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst_n) begin
        if (ovr_w[k]) ovr_n[k]++;
        if (und_w[k]) und_n[k]++;
        if (abt_w[k]) abt_n[k]++;
        if (rxv_w[k] && rxr_p[k]) got[k].push_back(rxval(k));
        if (rxv_w[k] && !rxv_prev[k]) rv_cyc[k] = cyc;
      end
      rxv_prev[k] = rxv_w[k];
    end
  end

  // TX feeder: presents queued words to each slave in order.
  int   txi[4];
  logic hs[4];
  initial begin
    txd0 = '0;
    for (int k = 0; k < 4; k++) begin
      txv_p[k] = 1'b0;
      txi[k]   = 0;
      hs[k]    = 1'b0;
      if (k != 0) txd16[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) hs[k] = txv_p[k] && txr_w[k] && rst_n;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (hs[k]) begin
          txi[k]++;
          txv_p[k] = 1'b0;
        end
        if (!txv_p[k] && txi[k] < txq[k].size()) begin
          txv_p[k] = 1'b1;
          if (k == 0) txd0 = txq[k][txi[k]][7:0];
          else        txd16[k] = txq[k][txi[k]][15:0];
        end
      end
    end
  end

  task automatic wait_c(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_loaded(input int k);
    for (int i = 0; i < 40 && txr_w[k]; i++) wait_c(1);
    check($sformatf("txload%0d", k), {31'b0, txr_w[k]}, 32'd0);
  endtask

  // Behavioural SPI master: m_tx words out, m_rx words captured.
  logic [31:0] m_tx[8], m_rx[8];

  task automatic frame(input int k, input int nbits,
                       input bit late_en, input logic [31:0] late_w);
    int w, wi, bi;
    bit cpha, lsb;
    w    = (k == 0) ? 8 : 16;
    cpha = (k % 2) == 1;
    lsb  = (k != 0);
    for (int i = 0; i < 8; i++) m_rx[i] = '0;
    sck_p[k] = (k >= 2);
    csn_p[k] = 1'b0;
    wait_c(HALF);
    if (late_en) txq[k].push_back(late_w);
    for (int b = 0; b < nbits; b++) begin
      wi = b / w;
      bi = lsb ? (b % w) : (w - 1 - b % w);
      if (!cpha) begin
        mosi_p[k] = m_tx[wi][bi];
        wait_c(HALF);
        m_rx[wi][bi] = miso_w[k];
        smp_cyc[k] = cyc;
        sck_p[k] = ~sck_p[k];
        wait_c(HALF);
        sck_p[k] = ~sck_p[k];
      end else begin
        sck_p[k] = ~sck_p[k];
        mosi_p[k] = m_tx[wi][bi];
        wait_c(HALF);
        m_rx[wi][bi] = miso_w[k];
        smp_cyc[k] = cyc;
        sck_p[k] = ~sck_p[k];
        wait_c(HALF);
      end
    end
    if (!cpha) wait_c(HALF);
    csn_p[k]  = 1'b1;
    mosi_p[k] = 1'b0;
    wait_c(2 * HALF);
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s miso%0d", tag, k), {31'b0, miso_w[k]}, 0);
      check($sformatf("%s oe%0d", tag, k), {31'b0, oe_w[k]}, 0);
      check($sformatf("%s rxv%0d", tag, k), {31'b0, rxv_w[k]}, 0);
      check($sformatf("%s rxd%0d", tag, k), rxval(k), 0);
      check($sformatf("%s txr%0d", tag, k), {31'b0, txr_w[k]}, 1);
      check($sformatf("%s pulses%0d", tag, k),
            {29'b0, ovr_w[k], und_w[k], abt_w[k]}, 0);
      check($sformatf("%s busy%0d", tag, k), {31'b0, busy_w[k]}, 0);
    end
  endtask

  // One-word frame with a spare TX word so the completion load is covered.
  task automatic run_vec(input string tag, input int k,
                         input logic [31:0] tx, input logic [31:0] mo,
                         input logic [31:0] exp_rx, input logic [31:0] exp_mi);
    int w, g0, u0, o0;
    logic [31:0] mask;
    w    = (k == 0) ? 8 : 16;
    mask = (k == 0) ? 32'hFF : 32'hFFFF;
    txq[k].push_back(tx);
    txq[k].push_back($urandom & mask);
    wait_loaded(k);
    rxr_p[k] = 1'b1;
    g0 = got[k].size();
    u0 = und_n[k];
    o0 = ovr_n[k];
    m_tx[0] = mo;
    frame(k, w, 1'b0, '0);
    check({tag, " nrx"}, 32'(got[k].size() - g0), 1);
    check({tag, " rx"}, (got[k].size() > g0) ? got[k][g0] : 'x, exp_rx);
    check({tag, " miso"}, m_rx[0], exp_mi);
    check({tag, " und"}, 32'(und_n[k] - u0), 0);
    check({tag, " ovr"}, 32'(ovr_n[k] - o0), 0);
    check({tag, " lat"}, 32'(rv_cyc[k] - smp_cyc[k]), LAT);
  endtask

  typedef struct {
    int          k;
    logic [31:0] tx;
    logic [31:0] mo;
    logic [31:0] exp_rx;
    logic [31:0] exp_mi;
  } vec_t;

  vec_t vt[10];

  initial begin
    int a0, u0, o0, g0, n, k, w;
    logic [31:0] mask;
    vt[0] = '{0, 32'hA5,   32'h3C,   32'h3C,   32'hA5};
    vt[1] = '{1, 32'hBEEF, 32'h1234, 32'h1234, 32'hBEEF};
    vt[2] = '{2, 32'hBEEF, 32'h1234, 32'h1234, 32'hBEEF};
    vt[3] = '{3, 32'hBEEF, 32'h1234, 32'h1234, 32'hBEEF};
    vt[4] = '{0, 32'hFF,   32'h00,   32'h00,   32'hFF};
    vt[5] = '{0, 32'h00,   32'hFF,   32'hFF,   32'h00};
    vt[6] = '{0, 32'h81,   32'h7E,   32'h7E,   32'h81};
    vt[7] = '{1, 32'h0001, 32'h8000, 32'h8000, 32'h0001};
    vt[8] = '{2, 32'h8000, 32'h0001, 32'h0001, 32'h8000};
    vt[9] = '{3, 32'hFFFF, 32'h0000, 32'h0000, 32'hFFFF};

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sck_p[i]  = (i >= 2);
      csn_p[i]  = 1'b1;
      mosi_p[i] = 1'b0;
      rxr_p[i]  = 1'b0;
      ovr_n[i]  = 0;
      und_n[i]  = 0;
      abt_n[i]  = 0;
      rv_cyc[i] = 0;
      smp_cyc[i] = 0;
    end
    wait_c(3);
    check_reset("por");
    rst_n = 1'b1;
    wait_c(4);

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("vec%0d", i), vt[i].k, vt[i].tx, vt[i].mo,
              vt[i].exp_rx, vt[i].exp_mi);

    // Three words, consumer stalled: first word held, two overruns.
    rxr_p[0] = 1'b0;
    for (int i = 0; i < 4; i++) txq[0].push_back(32'h11 * (i + 1));
    wait_loaded(0);
    m_tx[0] = 32'h9C; m_tx[1] = 32'h2D; m_tx[2] = 32'hE7;
    o0 = ovr_n[0]; u0 = und_n[0]; g0 = got[0].size();
    frame(0, 24, 1'b0, '0);
    check("b2b rxd", {24'b0, rxd0}, 32'h9C);
    check("b2b rxv", {31'b0, rxv_w[0]}, 1);
    check("b2b ovr", 32'(ovr_n[0] - o0), 2);
    check("b2b und", 32'(und_n[0] - u0), 0);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b miso%0d", i), m_rx[i], 32'h11 * (i + 1));
    rxr_p[0] = 1'b1;
    wait_c(3);
    check("b2b nrx", 32'(got[0].size() - g0), 1);
    check("b2b rx", (got[0].size() > g0) ? got[0][g0] : 'x, 32'h9C);
    check("b2b rxv clr", {31'b0, rxv_w[0]}, 0);

    // No TX data at CS fall.
    u0 = und_n[0]; g0 = got[0].size();
    m_tx[0] = 32'h96;
    frame(0, 8, 1'b1, 32'h55);
    check("und cnt", 32'(und_n[0] - u0), 1);
    check("und miso", m_rx[0], 32'h00);
    check("und rx", (got[0].size() > g0) ? got[0][g0] : 'x, 32'h96);

    // CS released after 5 of 8 bits.
    txq[0].push_back(32'hC3);
    wait_loaded(0);
    a0 = abt_n[0]; g0 = got[0].size();
    m_tx[0] = 32'h5A;
    frame(0, 5, 1'b0, '0);
    check("abt cnt", 32'(abt_n[0] - a0), 1);
    check("abt nrx", 32'(got[0].size() - g0), 0);
    check("abt rxv", {31'b0, rxv_w[0]}, 0);
    run_vec("post_abt", 0, 32'h6B, 32'hD2, 32'hD2, 32'h6B);

    // Reset pulsed in the middle of a word.
    txq[0].push_back(32'h3C);
    wait_loaded(0);
    csn_p[0] = 1'b0;
    wait_c(HALF);
    for (int b = 0; b < 3; b++) begin
      mosi_p[0] = 1'b1;
      wait_c(HALF);
      sck_p[0] = 1'b1;
      wait_c(HALF);
      sck_p[0] = 1'b0;
    end
    wait_c(HALF);
    a0 = abt_n[0];
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    csn_p[0]  = 1'b1;
    mosi_p[0] = 1'b0;
    wait_c(4);
    rst_n = 1'b1;
    wait_c(2 * HALF);
    check("midrst abt", 32'(abt_n[0] - a0), 0);
    run_vec("post_rst", 0, 32'h47, 32'hB8, 32'hB8, 32'h47);

    // Random multi-word frames against the word-level model.
    for (int it = 0; it < 8; it++) begin
      k    = $urandom_range(0, 3);
      n    = $urandom_range(1, 3);
      w    = (k == 0) ? 8 : 16;
      mask = (k == 0) ? 32'hFF : 32'hFFFF;
      for (int i = 0; i < n; i++) m_tx[i] = $urandom & mask;
      for (int i = 0; i <= n; i++) txq[k].push_back($urandom & mask);
      wait_loaded(k);
      rxr_p[k] = 1'b1;
      g0 = got[k].size(); u0 = und_n[k]; o0 = ovr_n[k];
      frame(k, n * w, 1'b0, '0);
      check($sformatf("rnd%0d nrx", it), 32'(got[k].size() - g0), n);
      for (int i = 0; i < n; i++) begin
        check($sformatf("rnd%0d rx%0d", it, i),
              (got[k].size() > g0 + i) ? got[k][g0 + i] : 'x, m_tx[i]);
        check($sformatf("rnd%0d miso%0d", it, i), m_rx[i],
              txq[k][txq[k].size() - 1 - n + i]);
      end
      check($sformatf("rnd%0d und", it), 32'(und_n[k] - u0), 0);
      check($sformatf("rnd%0d ovr", it), 32'(ovr_n[k] - o0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
